// File: rtl/aes_pkg.sv
// Shared AES helpers for the key-schedule blocks.
//   NR         : number of AES-128 rounds
//   rcon()     : round constant byte for round r (1..10), 0 elsewhere
//   wget()     : extract word i (w0 = [127:96] .. w3 = [31:0]) of a 128-bit key
//   gmul/ginv  : GF(2^8) multiply / multiplicative inverse (poly 0x11b)
package aes_pkg;

  localparam int NR = 10;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] wget(input logic [127:0] k, input int i);
    return k[127-32*i -: 32];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // a^254 == a^-1 (and maps 0 to 0): six square-and-multiply steps give
  // a^127, one final square gives a^254.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
    return gmul(r, r);
  endfunction

endpackage

// File: rtl/byte2S.sv
// Byte S-box. flag=0: forward AES S-box, flag=1: inverse S-box.
//   in   : input byte
//   flag : direction select
//   out  : substituted byte
module byte2S
  import aes_pkg::*;
(
  input  logic [7:0] in,
  input  logic       flag,
  output logic [7:0] out
);

  logic [7:0] fwd, inv_aff;

  // forward: affine(inverse(x)); inverse: inverse(affine^-1(x))
  always_comb begin
    fwd     = ginv(in);
    fwd     = fwd ^ {fwd[6:0], fwd[7]} ^ {fwd[5:0], fwd[7:6]}
                  ^ {fwd[4:0], fwd[7:5]} ^ {fwd[3:0], fwd[7:4]} ^ 8'h63;
    inv_aff = {in[6:0], in[7]} ^ {in[4:0], in[7:5]} ^ {in[1:0], in[7:2]} ^ 8'h05;
    out     = flag ? ginv(inv_aff) : fwd;
  end

endmodule

// File: rtl/key_inv_step.sv
// One reverse AES-128 key-expansion step: round key r -> round key r-1.
//   in    : round key r, w0 = [127:96] .. w3 = [31:0]
//   round : r, selects rcon[r]
//   out   : round key r-1
module key_inv_step
  import aes_pkg::*;
(
  input  logic [127:0] in,
  input  logic [3:0]   round,
  output logic [127:0] out
);

  logic [31:0] p0, p1, p2, p3, rot, sub;

  assign p3  = wget(in, 3) ^ wget(in, 2);
  assign p2  = wget(in, 2) ^ wget(in, 1);
  assign p1  = wget(in, 1) ^ wget(in, 0);
  assign rot = {p3[23:0], p3[31:24]};

  // the schedule runs SubWord forward even when walking backwards
  for (genvar i = 0; i < 4; i++) begin : g_sb
    byte2S u_sb (.in(rot[8*i +: 8]), .flag(1'b0), .out(sub[8*i +: 8]));
  end

  assign p0  = wget(in, 0) ^ sub ^ {rcon(round), 24'h0};
  assign out = {p0, p1, p2, p3};

endmodule

// File: rtl/key_inv_expand.sv
// Reverse AES-128 key-schedule walker. Loads the round-NR key and streams
// round keys NR..0 over a valid/ready interface, one step per handshake.
//   start/key_last : load request (taken only while ready) and round-NR key
//   abort          : drop the stream and return to idle (beats a handshake)
//   ready          : idle, will accept start
//   rkey/rkey_round/rkey_valid/rkey_ready : round key output stream
//   done           : one-cycle pulse after the round-0 key is taken
module key_inv_expand #(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_last,
  input  logic         abort,
  output logic         ready,
  output logic [127:0] rkey,
  output logic [3:0]   rkey_round,
  output logic         rkey_valid,
  input  logic         rkey_ready,
  output logic         done
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [3:0] NR4 = 4'(NR);

  state_t       state;
  logic [127:0] step_out;

  key_inv_step u_step (.in(rkey), .round(rkey_round), .out(step_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ready      <= 1'b1;
      rkey       <= '0;
      rkey_round <= '0;
      rkey_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        rkey_valid <= 1'b0;
        ready      <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start) begin
            state      <= EMIT;
            rkey       <= key_last;
            rkey_round <= NR4;
            rkey_valid <= 1'b1;
            ready      <= 1'b0;
          end
          EMIT: if (rkey_ready) begin
            if (rkey_round == 4'd0) begin
              // rkey is left at the round-0 key
              state      <= IDLE;
              rkey_valid <= 1'b0;
              ready      <= 1'b1;
              done       <= 1'b1;
            end else begin
              rkey       <= step_out;
              rkey_round <= rkey_round - 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_inv_expand.sv
module tb_key_inv_expand;

  logic         clk = 1'b0;
  logic         rst_n, start, abort, rkey_ready;
  logic [127:0] key_last;
  logic         ready, rkey_valid, done;
  logic [127:0] rkey;
  logic [3:0]   rkey_round;

  always #5 clk = ~clk;

  key_inv_expand dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_last(key_last), .abort(abort),
    .ready(ready), .rkey(rkey), .rkey_round(rkey_round), .rkey_valid(rkey_valid),
    .rkey_ready(rkey_ready), .done(done)
  );

  typedef struct packed { logic [3:0] r; logic [127:0] k; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0, done_seen = 0;
  logic [127:0] a1 [0:10];
  logic [127:0] zk [0:10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  // ---- independent reference: polynomial multiply + brute-force inverse
  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv, s, c;
    inv = 8'h00;
    c   = 8'h63;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++) if (m_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  // forward FIPS-197 key expansion of key0 into zk[0..10]
  task automatic expand(input logic [127:0] key0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc [1:10];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = key0[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])}
            ^ {rc[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) zk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_seq(input int which);
    for (int r = 10; r >= 0; r--)
      exp_q.push_back('{r: 4'(r), k: (which == 0) ? a1[r] : zk[r]});
  endtask

  // ---- monitor: pops on every accepted key, checks holds and done pulses
  logic         stall_prev = 1'b0, last_r0 = 1'b0;
  logic [127:0] held_k;
  logic [3:0]   held_r;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stall_prev) begin
        chk("hold_valid", 128'(rkey_valid), 128'(1));
        chk("hold_key", rkey, held_k);
        chk("hold_round", 128'(rkey_round), 128'(held_r));
      end
      if (done) begin
        done_seen++;
        chk("done_after_r0", 128'(last_r0), 128'(1));
        chk("done_ready", 128'(ready), 128'(1));
        chk("done_valid", 128'(rkey_valid), 128'(0));
      end
      if (rkey_valid && rkey_ready && !abort) begin
        if (exp_q.size() == 0) chk("unexpected_key", 128'(exp_q.size()), 128'(1));
        else begin
          e = exp_q.pop_front();
          chk("rkey", rkey, e.k);
          chk("rkey_round", 128'(rkey_round), 128'(e.r));
        end
      end
      last_r0    = rkey_valid && rkey_ready && !abort && (rkey_round == 4'd0);
      stall_prev = rkey_valid && !rkey_ready && !abort;
      held_k     = rkey;
      held_r     = rkey_round;
    end else begin
      stall_prev = 1'b0;
      last_r0    = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start one run and wait for done; bp = random backpressure,
  // busy = poke start/key_last while the walk is in progress
  task automatic run(input logic [127:0] key, input bit bp, input bit busy);
    int cnt, d0;
    d0 = done_seen;
    key_last = key; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 300) begin
      if (bp) rkey_ready = 1'($urandom_range(0, 1));
      if (busy && (cnt == 2 || cnt == 6)) begin start = 1'b1; key_last = ~key; end
      else start = 1'b0;
      tick();
      cnt++;
    end
    start = 1'b0; rkey_ready = 1'b1; key_last = key;
    if (!bp) chk("done_latency", 128'(cnt), 128'(11));
    else chk("done_timeout", 128'(cnt < 300), 128'(1));
    chk("q_empty", 128'(exp_q.size()), 128'(0));
    chk("ready_after", 128'(ready), 128'(1));
    tick();
    chk("done_pulse_len", 128'(done), 128'(0));
    chk("done_count", 128'(done_seen - d0), 128'(1));
  endtask

  task automatic wait_round(input logic [3:0] r);
    int cnt = 0;
    while (!(rkey_valid && rkey_round == r) && cnt < 50) begin tick(); cnt++; end
    chk("wait_round_timeout", 128'(cnt < 50), 128'(1));
  endtask

  initial begin
    a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rkey_ready = 1'b1; key_last = '0;
    #12;
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_rkey", rkey, 128'(0));
    chk("rst_round", 128'(rkey_round), 128'(0));
    chk("rst_valid", 128'(rkey_valid), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // FIPS-197 A.1, continuous ready
    push_seq(0);
    run(a1[10], 1'b0, 1'b0);

    // random backpressure
    push_seq(0);
    run(a1[10], 1'b1, 1'b0);

    // all-zero cipher key, expected keys from the forward model
    expand(128'h0);
    push_seq(1);
    run(zk[10], 1'b0, 1'b0);

    // abort coincident with the round-5 handshake
    push_seq(0);
    key_last = a1[10]; start = 1'b1;
    tick();
    start = 1'b0;
    wait_round(4'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 128'(rkey_valid), 128'(0));
    chk("abort_ready", 128'(ready), 128'(1));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_remaining", 128'(exp_q.size()), 128'(6));
    exp_q.delete();
    tick();
    push_seq(0);
    run(a1[10], 1'b0, 1'b0);

    // asynchronous reset between clock edges, mid-sequence
    push_seq(1);
    key_last = zk[10]; start = 1'b1;
    tick();
    start = 1'b0;
    wait_round(4'd6);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ready", 128'(ready), 128'(1));
    chk("arst_rkey", rkey, 128'(0));
    chk("arst_round", 128'(rkey_round), 128'(0));
    chk("arst_valid", 128'(rkey_valid), 128'(0));
    chk("arst_done", 128'(done), 128'(0));
    exp_q.delete();
    #1 rst_n = 1'b1;
    tick();
    push_seq(0);
    run(a1[10], 1'b0, 1'b0);

    // start and key_last changes while busy are ignored
    push_seq(0);
    run(a1[10], 1'b0, 1'b1);

    // start together with abort in idle: start is dropped
    key_last = a1[10]; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_valid", 128'(rkey_valid), 128'(0));
    chk("abort_start_ready", 128'(ready), 128'(1));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
